// File: rtl/seg7_ctrl_pkg.sv
// Shared definitions for the 7-segment shifter control blocks:
// FSM encoding, default word width and a clog2 helper.
package seg7_ctrl_pkg;

  localparam int DEFAULT_DATA_BITS = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    DONE    = 3'd4
  } seg7_state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/seg7_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above
// pointer, wrapping around to index 0.
module seg7_rr_pick
  import seg7_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    pointer,
  output logic             valid,
  output logic [IW-1:0]    index
);

  function automatic int wrap(input int s);
    return (s >= N_REQ) ? s - N_REQ : s;
  endfunction

  // Scan from the far end down so the candidate closest to pointer wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[wrap(int'(pointer) + i)]) begin
        valid = 1'b1;
        index = IW'(wrap(int'(pointer) + i));
      end
    end
  end

endmodule

// File: rtl/seg7_p2s_arbiter.sv
// Round-robin arbiter that shares one 7-segment parallel-to-serial shifter
// between several display clients and reports per-client completion.
module seg7_p2s_arbiter
  import seg7_ctrl_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter  int START_CYC   = 3,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int IW          = clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_BITS-1:0] req_data,
  output logic [N_REQ-1:0]           ack,
  output logic                       err,
  output logic                       busy,
  output logic [IW-1:0]              grant_id,
  output logic                       p2s_start,
  output logic [DATA_BITS-1:0]       p2s_pdata,
  input  logic                       p2s_en,
  output logic [2:0]                 state_dbg
);

  localparam int CMAX = (TIMEOUT_CYC > START_CYC) ? TIMEOUT_CYC : START_CYC;
  localparam int CW   = clog2(CMAX + 1);

  // Handshake: req is a level held until the one-cycle ack pulse; the
  // shifter is started by p2s_start and reports completion via p2s_en
  // falling (shifting) and then rising again (idle).

  seg7_state_t          state;
  logic [IW-1:0]        rr_ptr;
  logic [CW-1:0]        cnt;
  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;
  logic [N_REQ-1:0]     grant_onehot;
  logic [DATA_BITS-1:0] words [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = req_data[g*DATA_BITS +: DATA_BITS];
  end

  seg7_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req     (req),
    .pointer (rr_ptr),
    .valid   (pick_valid),
    .index   (pick_idx)
  );

  assign grant_onehot = N_REQ'(1) << grant_id;
  assign busy         = (state != IDLE);
  assign state_dbg    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      ack       <= '0;
      err       <= 1'b0;
      grant_id  <= '0;
      p2s_start <= 1'b0;
      p2s_pdata <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id  <= pick_idx;
            p2s_pdata <= words[pick_idx];
            p2s_start <= 1'b1;
            cnt       <= '0;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (cnt == CW'(START_CYC - 1)) begin
            p2s_start <= 1'b0;
            cnt       <= '0;
            state     <= WAIT_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!p2s_en) begin
            cnt   <= '0;
            state <= WAIT_HI;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            ack   <= grant_onehot;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HI: begin
          if (p2s_en) begin
            ack   <= grant_onehot;
            state <= DONE;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            ack   <= grant_onehot;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Next search starts just past the client that was served.
          rr_ptr <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
          cnt    <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_p2s_arbiter.sv
// Directed bench for seg7_p2s_arbiter: a shifter model answers Start pulses,
// expected acks are queued by the stimulus and checked by a monitor.
module tb_seg7_p2s_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 64;
  localparam int START = 3;
  localparam int TMO   = 1024;
  localparam int EW    = 1 + N_REQ + DW;

  logic                 clk;
  logic                 rst;
  logic [N_REQ-1:0]     req;
  logic [N_REQ*DW-1:0]  req_data;
  logic [N_REQ-1:0]     ack;
  logic                 err;
  logic                 busy;
  logic [1:0]           grant_id;
  logic                 p2s_start;
  logic [DW-1:0]        p2s_pdata;
  logic                 p2s_en;
  logic [2:0]           state_dbg;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;
  logic [DW-1:0] d [N_REQ];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int en_rise_cyc = 0;
  int fall_cyc = 0;
  int ack_cyc = 0;
  int start_w = 0;
  int rises = 0;
  int rises_before;
  int model_mode = 0;
  int drop_dly = 2;
  int hi_dly = 130;
  logic prev_start = 1'b0;

  seg7_p2s_arbiter #(
    .N_REQ       (N_REQ),
    .DATA_BITS   (DW),
    .START_CYC   (START),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .err       (err),
    .busy      (busy),
    .grant_id  (grant_id),
    .p2s_start (p2s_start),
    .p2s_pdata (p2s_pdata),
    .p2s_en    (p2s_en),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Shifter model: EN falls drop_dly cycles after a Start rise, rises hi_dly later.
  initial begin
    p2s_en = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && p2s_start && !prev_start) begin
        rises++;
        if (model_mode == 0) begin
          repeat (drop_dly) @(posedge clk);
          #1 p2s_en = 1'b0;
          repeat (hi_dly) @(posedge clk);
          #1 p2s_en = 1'b1;
          en_rise_cyc = cyc;
        end
      end
      prev_start = p2s_start;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      start_w = 0;
    end else begin
      if (p2s_start) begin
        start_w++;
      end else if (start_w != 0) begin
        chk("start_width", start_w, START);
        if (exp_q.size() > 0) chk("pdata_at_start", p2s_pdata, exp_q[0][DW-1:0]);
        fall_cyc = cyc;
        start_w  = 0;
      end
      if (ack != '0) begin
        ack_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_ack: got ack=%b err=%b expected none", ack, err);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("ack_err_pdata", {err, ack, p2s_pdata}, mon_exp);
          if (!err && model_mode == 0) chk("ack_after_en_rise", cyc - en_rise_cyc, 1);
        end
      end else if (err) begin
        n_checks++;
        n_errors++;
        $display("FAIL err_without_ack: got err=1 expected 0");
      end
    end
  end

  // Driver tasks
  task automatic load_data();
    req_data = {d[3], d[2], d[1], d[0]};
  endtask

  task automatic push_exp(input logic e, input int idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    exp_q.push_back({e, oh, d[idx]});
  endtask

  task automatic wait_ack(input int idx, input int budget, input logic [N_REQ-1:0] drop);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (ack[idx]) seen = 1'b1;
    end
    if (seen) req = req & ~drop;
    chk($sformatf("ack%0d_seen", idx), seen, 1'b1);
  endtask

  task automatic wait_en(input logic level, input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (p2s_en == level) seen = 1'b1;
    end
    chk(name, seen, 1'b1);
  endtask

  initial begin
    d[0] = 64'h0123_4567_89AB_CDEF;
    d[1] = 64'hA5A5_0000_1111_2222;
    d[2] = 64'h0F0F_3333_4444_5555;
    d[3] = 64'hDEAD_BEEF_CAFE_F00D;
    load_data();
    req = '0;
    rst = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_start", p2s_start, 0);
    chk("rst_pdata", p2s_pdata, 0);
    chk("rst_state", state_dbg, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single request, slow shifter
    hi_dly = 130;
    push_exp(1'b0, 0);
    @(posedge clk); #1 req = 4'b0001;
    wait_ack(0, 300, 4'b0001);
    @(negedge clk);
    chk("t1_grant_id", grant_id, 0);
    chk("t1_idle", busy, 0);

    // All four continuously requesting from reset
    hi_dly = 5;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_exp(1'b0, 0);
    push_exp(1'b0, 1);
    push_exp(1'b0, 2);
    push_exp(1'b0, 3);
    push_exp(1'b0, 0);
    req = 4'b1111;
    wait_ack(0, 200, 4'b0000);
    wait_ack(1, 200, 4'b0000);
    wait_ack(2, 200, 4'b0000);
    wait_ack(3, 200, 4'b0000);
    wait_ack(0, 200, 4'b1111);

    // Data change and request drop mid-transfer
    repeat (2) @(negedge clk);
    push_exp(1'b0, 1);
    @(posedge clk); #1 req = 4'b0010;
    wait_en(1'b0, 50, "t3_en_low");
    d[1] = 64'hFFFF_EEEE_DDDD_CCCC;
    load_data();
    req[1] = 1'b0;
    wait_ack(1, 200, 4'b0000);
    @(negedge clk);
    chk("t3_grant_id_retained", grant_id, 1);

    // Timeout: shifter never leaves idle
    model_mode = 1;
    push_exp(1'b1, 2);
    @(posedge clk); #1 req = 4'b0100;
    wait_ack(2, 1200, 4'b0100);
    @(negedge clk);
    chk("t4_wait_lo_cycles", ack_cyc - fall_cyc, TMO);
    chk("t4_busy", busy, 0);
    chk("t4_state", state_dbg, 0);
    model_mode = 0;

    // Asynchronous reset during WAIT_HI, pointer returns to 0
    hi_dly = 40;
    @(posedge clk); #1 req = 4'b1000;
    wait_en(1'b0, 50, "t5_en_low");
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_state_pre", state_dbg, 0);
    chk("t5_ack", ack, 0);
    chk("t5_err", err, 0);
    chk("t5_busy", busy, 0);
    chk("t5_grant_id", grant_id, 0);
    chk("t5_start", p2s_start, 0);
    chk("t5_pdata", p2s_pdata, 0);
    req = 4'b1100;
    push_exp(1'b0, 2);
    push_exp(1'b0, 3);
    wait_en(1'b1, 100, "t5_en_high");
    @(posedge clk); #3 rst = 1'b0;
    wait_ack(2, 200, 4'b0100);
    wait_ack(3, 200, 4'b1000);

    // Back-to-back transfers
    hi_dly = 5;
    rises_before = rises;
    push_exp(1'b0, 0);
    push_exp(1'b0, 1);
    @(posedge clk); #1 req = 4'b0011;
    wait_ack(0, 200, 4'b0001);
    wait_ack(1, 200, 4'b0010);
    repeat (5) @(negedge clk);
    chk("t6_start_rises", rises - rises_before, 2);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
